csr_timer: RTL
==============

# csr_timer

32-bit down-counting timer that is a CSR-bus responder. It sits behind the WB-to-CSR bridge and decodes the 3-bit `csr_a` / `csr_we` / 16-bit data interface that the bridge drives. It provides:
- a reload register;
- auto-reload or one-shot mode;
- a sticky zero flag with level interrupt;
- a torn-read-safe 32-bit count readout.

## Interface
Parameters:
- `TIMER_ID`, default 16'h7431: constant returned at register 7.

Ports:
- `sys_clk` input 1: single clock.
- `sys_rst` input 1: asynchronous, active-high reset.
- `csr_a` input 3: register address, driven by the bridge.
- `csr_we` input 1: one-cycle write strobe.
- `csr_di` input 16: write data from the bridge.
- `csr_do` output 16: read data to the bridge, registered.
- `irq` output 1: level interrupt, registered.

## Operation
Register map (16-bit words):
- 0 CTRL:
  - bit0 EN, bit1 AUTO, bit2 IEN are R/W.
  - bit3 LOAD is write-only and self-clearing; it reads 0.
  - Bits 15:4 read 0.
- 1 STAT: bit0 ZF, sticky. Write 1 to clear; write 0 has no effect.
- 2 RELOAD_LO, 3 RELOAD_HI: R/W halves of the 32-bit reload value.
- 4 COUNT_LO: read-only; current count[15:0].
- 5 COUNT_HI: read-only; returns `shadow_hi`.
- 6 PRESCALE: R/W; tick divider (see Configuration).
- 7 ID: read-only; returns `TIMER_ID`.
- Writes to read-only addresses are ignored.

Counter behaviour:
- Counts on each tick while EN=1.
- Tick with count≠0: count decrements by 1.
- Tick with count==0:
  - ZF is set.
  - AUTO=1: count is loaded with RELOAD.
  - AUTO=0: EN clears and count stays 0.
- LOAD write: count is loaded with RELOAD and the prescaler restarts. LOAD takes effect even if EN=0.
- LOAD and tick in the same cycle: LOAD wins and the tick is discarded.
- STAT clear and zero event in the same cycle: set wins, so ZF stays 1.
- A CTRL write that sets EN and LOAD together loads first; counting starts on the next tick.

Shadow and interrupt:
- `shadow_hi` captures count[31:16] in every cycle where `csr_a==4`. Software must read LO before HI.
- `irq` = IEN & ZF.
- Arithmetic is a 32-bit unsigned decrement with no underflow wrap; zero is detected before decrementing.

## Timing
- Reset values:
  - `csr_do`=0 and `irq`=0.
  - CTRL, STAT, RELOAD, count, `shadow_hi`, PRESCALE and the prescaler counter are all 0.
- Write: the register updates at the edge where `csr_we=1`, using that cycle's `csr_a`/`csr_di`. No ack is involved; the bridge times the access.
- Read: `csr_do` equals the register selected by `csr_a`, registered, with 1-cycle latency. It updates every cycle regardless of `csr_we`. This fits within the bridge's 3-cycle read delay.
- `irq` asserts 1 cycle after ZF sets, or after IEN is written to 1 while ZF=1. It deasserts 1 cycle after the clear.
- Assertion of `sys_rst` mid-count returns all state to reset values immediately; no tick or write is honoured while reset is asserted.

## Configuration
`CSR_TIMER_PRESCALER_EN`:
- Defined:
  - A 16-bit prescaler issues a tick every PRESCALE+1 cycles while EN=1.
  - The prescaler counter clears when EN=0 and on LOAD.
  - A PRESCALE write takes effect at the next prescaler wrap.
- Undefined:
  - Tick = EN, i.e. every cycle.
  - Register 6 reads 0 and writes to it are ignored.

## Structure
- Package `csr_timer_pkg` holds:
  - register address constants (`CSR_TIMER_CTRL`…`CSR_TIMER_ID`);
  - CTRL bit indices (EN, AUTO, IEN, LOAD);
  - the STAT ZF index.
- Sub-module `csr_timer_prescaler`:
  - Inputs: `sys_clk`, `sys_rst`, `en`, `restart`, `div[15:0]`.
  - Output: `tick`.
  - Instantiated only under the macro.

## Test plan
- Reset then read all 8 registers → 0 except ID=16'h7431; `irq`=0.
- RELOAD=0x0000_0003, CTRL=0x000F (EN, AUTO, IEN, LOAD), no prescale:
  - Count sequence is 3,2,1,0,3.
  - ZF sets on the 0→reload tick; `irq` rises 1 cycle later.
- One-shot with RELOAD=2, CTRL=0x0009 → count reaches 0, ZF=1, EN reads 0, count holds 0.
- ZF=1: write STAT=1 in the same cycle as the next zero event → ZF remains 1. A later STAT=1 write with no event clears it, and `irq` falls 1 cycle later.
- Count 0x0001_0000, read COUNT_LO while a tick occurs, then COUNT_HI → HI/LO pair is consistent (0x0001/0x0000 or 0x0000/0xFFFF), never torn.
- With macro: PRESCALE=4, RELOAD=1, CTRL=0x000B (EN, AUTO, LOAD) → decrements occur exactly every 5 cycles. Without macro: PRESCALE reads 0 after a write of 4.

Source files
------------

// File: rtl/csr_timer_pkg.sv
// Shared register map and bit positions for the csr_timer CSR responder.
// Latency: n/a (constants only). Backpressure: n/a.
package csr_timer_pkg;

    localparam logic [2:0] CSR_TIMER_CTRL      = 3'd0;
    localparam logic [2:0] CSR_TIMER_STAT      = 3'd1;
    localparam logic [2:0] CSR_TIMER_RELOAD_LO = 3'd2;
    localparam logic [2:0] CSR_TIMER_RELOAD_HI = 3'd3;
    localparam logic [2:0] CSR_TIMER_COUNT_LO  = 3'd4;
    localparam logic [2:0] CSR_TIMER_COUNT_HI  = 3'd5;
    localparam logic [2:0] CSR_TIMER_PRESCALE  = 3'd6;
    localparam logic [2:0] CSR_TIMER_ID        = 3'd7;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IEN  = 2;
    localparam int CTRL_LOAD = 3;

    localparam int STAT_ZF   = 0;

endpackage

// File: rtl/csr_timer_prescaler.sv
// Tick divider: one tick every div+1 cycles while en; div is sampled at each wrap.
// Latency: first tick div+1 cycles after enable/restart. Backpressure: none.
module csr_timer_prescaler (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    input  logic        restart,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;
    logic [15:0] div_act;

    assign tick = en && !restart && (cnt == div_act);

    // div_act only follows div at a wrap or while idle, so reprogramming never shortens a period mid-flight
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt     <= '0;
            div_act <= '0;
        end else if (!en || restart) begin
            cnt     <= '0;
            div_act <= div;
        end else if (cnt == div_act) begin
            cnt     <= '0;
            div_act <= div;
        end else begin
            cnt     <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/csr_timer.sv
// 32-bit down-counting CSR timer with reload, one-shot/auto modes, sticky ZF irq; prescaler under CSR_TIMER_PRESCALER_EN.
// Latency: csr_do and irq are registered, 1 cycle. Backpressure: none, the bridge times every access.
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter logic [15:0] TIMER_ID = 16'h7431
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [2:0]  csr_a,
    input  logic        csr_we,
    input  logic [15:0] csr_di,
    output logic [15:0] csr_do,
    output logic        irq
);

    logic        en;
    logic        auto_rl;
    logic        ien;
    logic        zf;
    logic [31:0] reload;
    logic [31:0] count;
    logic [15:0] shadow_hi;
    logic        tick;
    logic [15:0] rd_dat;

    logic wr_ctrl;
    logic load;
    logic zero_evt;
    logic stat_clr;

    assign wr_ctrl  = csr_we && (csr_a == CSR_TIMER_CTRL);
    assign load     = wr_ctrl && csr_di[CTRL_LOAD];
    assign zero_evt = tick && !load && (count == 32'd0);
    assign stat_clr = csr_we && (csr_a == CSR_TIMER_STAT) && csr_di[STAT_ZF];

`ifdef CSR_TIMER_PRESCALER_EN
    logic [15:0] prescale;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            prescale <= '0;
        end else if (csr_we && (csr_a == CSR_TIMER_PRESCALE)) begin
            prescale <= csr_di;
        end
    end

    csr_timer_prescaler u_prescaler (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .restart (load),
        .div     (prescale),
        .tick    (tick)
    );
`else
    assign tick = en;
`endif

    // LOAD beats a coincident tick; zero is tested before the decrement so count never wraps
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            count <= '0;
        end else if (load) begin
            count <= reload;
        end else if (tick) begin
            if (count != 32'd0) begin
                count <= count - 32'd1;
            end else if (auto_rl) begin
                count <= reload;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ien     <= 1'b0;
        end else if (wr_ctrl) begin
            en      <= csr_di[CTRL_EN];
            auto_rl <= csr_di[CTRL_AUTO];
            ien     <= csr_di[CTRL_IEN];
        end else if (zero_evt && !auto_rl) begin
            en      <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            zf <= 1'b0;
        end else if (zero_evt) begin
            zf <= 1'b1;
        end else if (stat_clr) begin
            zf <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            reload <= '0;
        end else if (csr_we && (csr_a == CSR_TIMER_RELOAD_LO)) begin
            reload[15:0] <= csr_di;
        end else if (csr_we && (csr_a == CSR_TIMER_RELOAD_HI)) begin
            reload[31:16] <= csr_di;
        end
    end

    // Reading LO freezes the matching HI half so a LO-then-HI pair is never torn
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shadow_hi <= '0;
        end else if (csr_a == CSR_TIMER_COUNT_LO) begin
            shadow_hi <= count[31:16];
        end
    end

    always_comb begin
        rd_dat = '0;
        case (csr_a)
            CSR_TIMER_CTRL:      rd_dat = {13'd0, ien, auto_rl, en};
            CSR_TIMER_STAT:      rd_dat = {15'd0, zf};
            CSR_TIMER_RELOAD_LO: rd_dat = reload[15:0];
            CSR_TIMER_RELOAD_HI: rd_dat = reload[31:16];
            CSR_TIMER_COUNT_LO:  rd_dat = count[15:0];
            CSR_TIMER_COUNT_HI:  rd_dat = shadow_hi;
`ifdef CSR_TIMER_PRESCALER_EN
            CSR_TIMER_PRESCALE:  rd_dat = prescale;
`endif
            CSR_TIMER_ID:        rd_dat = TIMER_ID;
            default:             rd_dat = '0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            csr_do <= '0;
            irq    <= 1'b0;
        end else begin
            csr_do <= rd_dat;
            irq    <= ien && zf;
        end
    end

endmodule
